// File: rtl/control_unit.sv
// HRM CPU instruction sequencer: fetch/decode/execute FSM that drives every
// datapath strobe and counts retired instructions.
module control_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  ir_op,
    input  logic        R_zero,
    input  logic        R_neg,
    input  logic        inbox_empty,
    input  logic        outbox_full,
    output logic        wIR,
    output logic [1:0]  muxR,
    output logic        wR,
    output logic [1:0]  alu_op,
    output logic        wM,
    output logic        pc_inc,
    output logic        pc_jmp,
    output logic        rInbox,
    output logic        wOutbox,
    output logic        halted,
    output logic [15:0] icount
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEMRD  = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPUP   = 4'h6;
    localparam logic [3:0] OP_BUMPDN   = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;

    localparam logic [1:0] MUX_INBOX = 2'b00;
    localparam logic [1:0] MUX_MEM   = 2'b01;
    localparam logic [1:0] MUX_ALU   = 2'b10;

    logic [2:0]  state_q, state_d;
    logic [15:0] icount_q, icount_d;

    // Next-state and strobe decode; outputs follow state, opcode and status.
    always_comb begin
        state_d = state_q;
        wIR     = 1'b0;
        muxR    = 2'b00;
        wR      = 1'b0;
        alu_op  = 2'b00;
        wM      = 1'b0;
        pc_inc  = 1'b0;
        pc_jmp  = 1'b0;
        rInbox  = 1'b0;
        wOutbox = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                wIR     = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (ir_op)
                    OP_INBOX: begin
                        if (!inbox_empty) begin
                            muxR    = MUX_INBOX;
                            wR      = 1'b1;
                            rInbox  = 1'b1;
                            pc_inc  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_OUTBOX: begin
                        if (!outbox_full) begin
                            wOutbox = 1'b1;
                            pc_inc  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_COPYTO: begin
                        wM      = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_COPYFROM, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: state_d = ST_MEMRD;
                    OP_JUMP: begin
                        pc_jmp  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_JUMPZ: begin
                        if (R_zero) begin
                            pc_jmp = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_JUMPN: begin
                        if (R_neg) begin
                            pc_jmp = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEMRD: begin
                case (ir_op)
                    OP_COPYFROM: begin
                        muxR    = MUX_MEM;
                        wR      = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_ADD, OP_SUB: begin
                        alu_op  = (ir_op == OP_SUB) ? 2'b01 : 2'b00;
                        muxR    = MUX_ALU;
                        wR      = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_BUMPUP, OP_BUMPDN: begin
                        alu_op  = (ir_op == OP_BUMPDN) ? 2'b11 : 2'b10;
                        muxR    = MUX_ALU;
                        wR      = 1'b1;
                        state_d = ST_WB;
                    end
                    // The opcode cannot change mid-instruction; anything else is a fault.
                    default: state_d = ST_HALT;
                endcase
            end
            ST_WB: begin
                wM      = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // One retirement per PC update pulse; wraps naturally at 16 bits.
    always_comb begin
        if (pc_inc || pc_jmp) begin
            icount_d = icount_q + 16'd1;
        end else begin
            icount_d = icount_q;
        end
    end

    assign icount = icount_q;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_FETCH;
            icount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the HRM CPU core. Runs a fetch/decode/execute FSM over the 8-bit instruction register and generates every datapath strobe: register-input select `muxR` and write `wR`, ALU op, data-memory write, PC increment/jump, inbox pop and outbox push. It sits between the program memory/IR, the inbox/outbox FIFOs and the REG/ALU/data-memory datapath, and is the only block that drives `muxR`/`wR`.

## Interface
- No parameters; encodings below are fixed.
- clk  in  1  system clock; all state changes on posedge.
- rstn  in  1  asynchronous, active-low reset.
- ir_op  in  4  opcode field IR[7:4], valid from the cycle after `wIR`.
- R_zero  in  1  register R == 0.
- R_neg  in  1  R[7] (R is signed 8-bit).
- inbox_empty  in  1  inbox FIFO has no data.
- outbox_full  in  1  outbox FIFO cannot accept data.
- wIR  out  1  latch program-memory output into IR.
- muxR  out  2  R source: 00 iInbox, 01 iMem, 10 iAlu; 11 never driven.
- wR  out  1  write R at the next posedge.
- alu_op  out  2  00 R+M, 01 R−M, 10 M+1, 11 M−1.
- wM  out  1  write R into data memory at IR[3:0].
- pc_inc  out  1  PC <= PC+1.
- pc_jmp  out  1  PC <= IR[3:0]; never asserted together with `pc_inc`.
- rInbox  out  1  pop inbox.
- wOutbox  out  1  push R into outbox.
- halted  out  1  FSM in HALT.
- icount  out  16  retired-instruction counter.

## Operation
- Opcodes: 0 INBOX, 1 OUTBOX, 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMPUP, 7 BUMPDN, 8 JUMP, 9 JUMPZ, A JUMPN, F HALT; B–E illegal, treated as HALT.
- States: FETCH, DECODE, EXEC, MEMRD, WB, HALT.
- FETCH: program memory (sync read, addr = PC) settles; no strobes; -> DECODE.
- DECODE: `wIR`=1; -> EXEC.
- EXEC by `ir_op`:
  - INBOX: if `inbox_empty` stay in EXEC, no strobes; else `muxR`=00, `wR`, `rInbox`, `pc_inc`; -> FETCH.
  - OUTBOX: if `outbox_full` stay; else `wOutbox`, `pc_inc`; -> FETCH.
  - COPYTO: `wM`, `pc_inc`; -> FETCH.
  - COPYFROM/ADD/SUB/BUMPUP/BUMPDN: no strobes (data-memory sync read); -> MEMRD.
  - JUMP: `pc_jmp`; JUMPZ: `pc_jmp` if `R_zero`, else `pc_inc`; JUMPN: `pc_jmp` if `R_neg`, else `pc_inc`; -> FETCH.
  - HALT/illegal: -> HALT, no strobes.
- MEMRD: COPYFROM: `muxR`=01, `wR`, `pc_inc` -> FETCH. ADD/SUB: `alu_op`=00/01, `muxR`=10, `wR`, `pc_inc` -> FETCH. BUMPUP/BUMPDN: `alu_op`=10/11, `muxR`=10, `wR` -> WB.
- WB (BUMP only): `wM` (memory <= new R), `pc_inc`; -> FETCH.
- HALT: absorbing; `halted`=1; all strobes 0; exit only via reset.
- Outputs are combinational from state, `ir_op` and status inputs. Unlisted outputs are 0; `muxR`/`alu_op` are 00 when not in use.
- `icount` increments on every cycle with `pc_inc` or `pc_jmp` (one per retired instruction), wraps 0xFFFF -> 0x0000, and does not count HALT.

## Timing
- Reset: state FETCH, `icount`=0. Outputs settle combinationally to FETCH values (all strobes 0, `muxR`=00, `alu_op`=00, `halted`=0) while `rstn`=0.
- Reset asserted mid-instruction aborts it immediately; any partial effects already clocked into the datapath remain.
- First `wIR` occurs in the 2nd cycle after reset release.
- Latency per instruction, FETCH to FETCH: 3 cycles for INBOX/OUTBOX (no stall), COPYTO and the JUMPs; 4 for COPYFROM/ADD/SUB; 5 for BUMPs.
- INBOX/OUTBOX stalls add one cycle per cycle of `inbox_empty`/`outbox_full`. The strobe fires in the first EXEC cycle the condition is clear.
- `rInbox` and `wR` assert in the same cycle; R captures the FIFO head at that edge.
- JUMPZ/JUMPN sample `R_zero`/`R_neg` in EXEC, which reflects any R write from the previous instruction.
- Exactly one `pc_inc`/`pc_jmp` pulse per instruction, always in its last cycle. PC updates at that edge, so FETCH sees the new PC.

## Test plan
- Reset, then ir_op=3 (COPYTO): 3-cycle sequence FETCH, DECODE (`wIR`=1), EXEC (`wM`=1, `pc_inc`=1); `icount`=1.
- INBOX with `inbox_empty`=1 for 4 cycles, then 0: EXEC held 4 cycles with no strobes; next cycle `muxR`=00, `wR`=1, `rInbox`=1 together; total 7 cycles.
- ADD then SUB: MEMRD asserts `alu_op`=00 (then 01), `muxR`=10, `wR`=1; 4 cycles each; no `wM`.
- BUMPDN: MEMRD `alu_op`=11, `muxR`=10, `wR`=1; WB `wM`=1, `pc_inc`=1; 5 cycles; `wR` and `wM` never in the same cycle.
- JUMPZ with `R_zero`=1 gives `pc_jmp`=1, `pc_inc`=0; with `R_zero`=0 gives `pc_inc`=1. JUMPN likewise with `R_neg`.
- ir_op=0xC: HALT entered, `halted`=1 and all strobes 0 for 20 cycles; `rstn` pulse low returns to FETCH with `icount`=0. Separately, force `icount` to 0xFFFF and retire one instruction: `icount`=0x0000.
